cc_miss_req_unit: RTL and testbench
===================================

# cc_miss_req_unit

Cache-controller miss request stage, directly upstream of the data fill unit. Accepts line-miss requests from the tag-compare pipeline and issues one AXI read-address burst per miss: 8 beats × 64 bit, WRAP, critical-word-first. Records each miss address in an internal miss-address FIFO whose read port is consumed by the fill unit. Limits outstanding fills by tracking R-channel `rlast` handshakes.

## Interface
- FIFO_DEPTH, 4, miss-address FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 4, maximum issued-but-unfilled bursts; 1..FIFO_DEPTH
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- miss_req_valid_i  in  1  miss request valid
- miss_req_addr_i  in  32  byte address of missing word
- miss_req_ready_o  out  1  request accepted when valid & ready
- mem_arvalid_o  out  1  AXI AR valid
- mem_arready_i  in  1  AXI AR ready
- mem_araddr_o  out  32  {addr[31:3], 3'b000}
- mem_arlen_o  out  4  constant 4'd7
- mem_arsize_o  out  3  constant 3'b011
- mem_arburst_o  out  2  constant 2'b10 (WRAP)
- mem_rlast_i  in  1  R last beat
- mem_rvalid_i  in  1  R valid
- mem_rready_i  in  1  R ready (driven by controller)
- miss_addr_fifo_empty_o  out  1  FIFO empty
- miss_addr_fifo_rdata_o  out  32  head entry (show-ahead)
- miss_addr_fifo_rden_i  in  1  pop head

## Operation
- FSM states: IDLE, AR_WAIT.
- miss_req_ready_o = (state==IDLE) & !fifo_full & (outstanding < MAX_OUTSTANDING). Purely combinational from registered state.
- Accept (IDLE, valid&ready):
  - araddr register ← {addr[31:3],3'b0}.
  - FIFO push of the same 8-byte-aligned value; bits [5:3] are kept so the fill unit can rotate the wrap.
  - outstanding += 1.
  - Next state is AR_WAIT.
- AR_WAIT:
  - mem_arvalid_o=1. araddr is held stable until mem_arready_i.
  - On arready, go to IDLE; arvalid drops the next cycle.
  - No new request is accepted in AR_WAIT.
- outstanding counter: width clog2(MAX_OUTSTANDING+1).
  - Decrements on mem_rvalid_i & mem_rready_i & mem_rlast_i.
  - Accept and rlast in the same cycle leave it unchanged.
  - rlast with outstanding==0 is ignored (saturate at 0).
- FIFO: circular, read/write pointers with an extra wrap bit.
  - full = (ptr MSBs differ & low bits equal).
  - empty = (pointers equal).
  - Push and pop in the same cycle are both performed, including when full: pop frees the slot, push is still blocked by ready, so no overflow.
  - Pop when empty is ignored; pointers are unchanged.
  - rdata_o = mem[rd_ptr] combinationally.
- Duplicate line misses are not merged; each accepted request produces its own burst and FIFO entry.

## Timing
- Reset values:
  - state=IDLE, mem_arvalid_o=0, mem_araddr_o=0, outstanding=0.
  - FIFO pointers=0, miss_addr_fifo_empty_o=1, all FIFO entries and miss_addr_fifo_rdata_o=0.
  - miss_req_ready_o=1 (when MAX_OUTSTANDING≥1).
- Accept in cycle N:
  - mem_arvalid_o=1 and miss_addr_fifo_empty_o=0 at N+1.
  - The entry is visible on rdata_o at N+1.
- arready sampled high in cycle M with arvalid=1: arvalid=0 and ready_o may be 1 at M+1.
- arready combinationally high is tolerated; the minimum spacing of back-to-back ARs is 2 cycles.
- Outstanding limit is reached in cycle N: ready_o is low from N+1 until the cycle after the freeing rlast handshake.
- Reset asserted mid-burst returns everything to reset values on the next edge. Pending AR and FIFO contents are discarded; the system resets the AXI slave simultaneously.
- Constant AR fields (len/size/burst) are driven at all times, including during reset.

## Test plan
- Single miss: addr 0x0001_2368, arready=1 one cycle after arvalid.
  - Expect: araddr=0x0001_2368, len=7, burst=2'b10, one AR handshake.
  - FIFO rdata=0x0001_2368, empty=0.
  - Eight R beats with rlast return outstanding to 0.
- AR back-pressure: arready held low 5 cycles.
  - Expect: araddr stable and arvalid=1 throughout.
  - ready_o=0 throughout; exactly one handshake.
- Outstanding limit (MAX=4, no R traffic): 5 requests offered.
  - Expect: 4 ARs issued, ready_o=0 after the 4th.
  - One rlast handshake re-enables acceptance; the 5th AR issues 2 cycles later.
- Simultaneous: accept and rlast handshake in the same cycle with outstanding=2 → stays 2.
  - Push and pop in the same cycle with FIFO at 3 entries → stays 3, order preserved.
- FIFO wrap: 10 push/pop pairs with addresses 0x100·k.
  - Expect: pop order matches push order across the pointer wrap.
  - Empty asserted only when the count is 0; pop-when-empty leaves pointers unchanged.
- Reset mid-operation: assert rst while in AR_WAIT with 2 FIFO entries.
  - Expect next cycle: arvalid=0, empty=1, rdata=0, ready_o=1, outstanding=0.

Source files
------------

// File: rtl/cc_miss_req_unit.sv
// Miss request stage: one 8x64b WRAP AXI read burst per accepted line miss, miss address queued for the fill unit.
// AR valid one cycle after accept; requests stall while an AR is pending, the FIFO is full or too many fills are outstanding.

module cc_miss_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module cc_miss_req_unit #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rlast_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    output logic        miss_addr_fifo_empty_o,
    output logic [31:0] miss_addr_fifo_rdata_o,
    input  logic        miss_addr_fifo_rden_i
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, AR_WAIT} state_t;

    state_t        state;
    logic [OW-1:0] outstanding;
    logic          fifo_full;
    logic          accept;
    logic          fill_done;
    logic [31:0]   line_addr;

    assign mem_arlen_o   = 4'd7;
    assign mem_arsize_o  = 3'b011;
    assign mem_arburst_o = 2'b10;

    // Word offset [5:3] survives so the fill unit can rotate the critical-word-first wrap.
    assign line_addr = miss_req_addr_i & 32'hFFFF_FFF8;

    assign miss_req_ready_o = (state == IDLE) && !fifo_full && (outstanding < MAX_CNT);
    assign accept           = miss_req_valid_i && miss_req_ready_o;
    // A stray rlast with nothing outstanding is dropped rather than underflowing.
    assign fill_done        = mem_rvalid_i && mem_rready_i && mem_rlast_i && (outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem_arvalid_o <= 1'b0;
            mem_araddr_o  <= '0;
            outstanding   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_araddr_o  <= line_addr;
                        mem_arvalid_o <= 1'b1;
                        state         <= AR_WAIT;
                    end
                end
                AR_WAIT: begin
                    if (mem_arready_i) begin
                        mem_arvalid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    mem_arvalid_o <= 1'b0;
                    state         <= IDLE;
                end
            endcase

            if (accept && !fill_done) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && fill_done) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    cc_miss_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_miss_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (line_addr),
        .pop      (miss_addr_fifo_rden_i),
        .full     (fifo_full),
        .empty    (miss_addr_fifo_empty_o),
        .rdata    (miss_addr_fifo_rdata_o)
    );
endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Randomized bench for cc_miss_req_unit: a queue-based reference model predicts
// AR addresses, FIFO contents and request readiness; a negedge monitor compares.
module tb_cc_miss_req_unit;
    localparam int FD = 4;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req_valid = 1'b0;
    logic [31:0] miss_req_addr = '0;
    logic        miss_req_ready;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_araddr;
    logic [3:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_rlast = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rden = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ar_q[$];
    logic [31:0] fill_q[$];
    bit m_busy = 1'b0;
    int m_cnt = 0;
    int m_out = 0;
    bit fresh = 1'b1;

    cc_miss_req_unit #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .miss_req_valid_i       (miss_req_valid),
        .miss_req_addr_i        (miss_req_addr),
        .miss_req_ready_o       (miss_req_ready),
        .mem_arvalid_o          (mem_arvalid),
        .mem_arready_i          (mem_arready),
        .mem_araddr_o           (mem_araddr),
        .mem_arlen_o            (mem_arlen),
        .mem_arsize_o           (mem_arsize),
        .mem_arburst_o          (mem_arburst),
        .mem_rlast_i            (mem_rlast),
        .mem_rvalid_i           (mem_rvalid),
        .mem_rready_i           (mem_rready),
        .miss_addr_fifo_empty_o (fifo_empty),
        .miss_addr_fifo_rdata_o (fifo_rdata),
        .miss_addr_fifo_rden_i  (fifo_rden)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: applies the rules at each active edge using the inputs held across it.
    always @(posedge clk) begin
        bit rdy, acc, pop, rl;
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_out  = 0;
            fresh  = 1'b1;
            ar_q.delete();
            fill_q.delete();
        end else begin
            rdy = !m_busy && (m_cnt < FD) && (m_out < MO);
            acc = miss_req_valid && rdy;
            pop = fifo_rden && (m_cnt > 0);
            rl  = mem_rvalid && mem_rready && mem_rlast && (m_out > 0);
            if (acc) begin
                ar_q.push_back(miss_req_addr & 32'hFFFF_FFF8);
                fill_q.push_back(miss_req_addr & 32'hFFFF_FFF8);
                fresh = 1'b0;
            end
            m_cnt = m_cnt + int'(acc) - int'(pop);
            m_out = m_out + int'(acc) - int'(rl);
            if (acc) m_busy = 1'b1;
            else if (m_busy && mem_arready) m_busy = 1'b0;
        end
    end

    // Monitor: compares DUT outputs mid-cycle, pops expectations on handshakes.
    always @(negedge clk) begin
        chk("arlen", 32'(mem_arlen), 32'd7);
        chk("arsize", 32'(mem_arsize), 32'd3);
        chk("arburst", 32'(mem_arburst), 32'd2);
        chk("ready", 32'(miss_req_ready), 32'(!m_busy && (m_cnt < FD) && (m_out < MO)));
        chk("arvalid", 32'(mem_arvalid), 32'(m_busy));
        chk("empty", 32'(fifo_empty), 32'(m_cnt == 0));
        if (fresh) begin
            chk("rdata_reset", fifo_rdata, 32'h0);
            chk("araddr_reset", mem_araddr, 32'h0);
        end
        if (m_busy) begin
            if (ar_q.size() == 0) begin
                chk("ar_expected", 32'(ar_q.size()), 32'd1);
            end else begin
                chk("araddr", mem_araddr, ar_q[0]);
                if (!rst && mem_arready) void'(ar_q.pop_front());
            end
        end
        if (m_cnt > 0) begin
            if (fill_q.size() == 0) begin
                chk("fifo_expected", 32'(fill_q.size()), 32'd1);
            end else begin
                chk("rdata", fifo_rdata, fill_q[0]);
                if (!rst && fifo_rden) void'(fill_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic ar,
                         input logic rv, input logic rr, input logic rl, input logic pop);
        @(posedge clk);
        #1;
        miss_req_valid = v;
        miss_req_addr  = a;
        mem_arready    = ar;
        mem_rvalid     = rv;
        mem_rready     = rr;
        mem_rlast      = rl;
        fifo_rden      = pop;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rnd(input int n, input int pv, input int par, input int pr, input int pp);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(99) < pv, $urandom, $urandom_range(99) < par,
                  $urandom_range(99) < pr, $urandom_range(99) < 80,
                  $urandom_range(99) < 40, $urandom_range(99) < pp);
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(2);

        // Single miss, arready one cycle after arvalid, then an 8-beat fill
        drive(1'b1, 32'h0001_2368, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, i == 7, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // AR back-pressure with a request held valid meanwhile
        drive(1'b1, 32'hCAFE_0F3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Outstanding limit: five requests offered, no R traffic, then one rlast frees a slot
        for (int i = 0; i < 14; i++) drive(1'b1, 32'h4000_0000 + 32'(i) * 32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h5555_5558, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h5555_5558, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // FIFO wrap: ten push/pop pairs, then pops while empty
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'h100 * 32'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0B07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Randomized traffic at several mixes
        rnd(600, 60, 50, 40, 50);
        rnd(600, 90, 20, 10, 20);
        rnd(600, 30, 90, 70, 80);

        // Reset while in AR_WAIT with two FIFO entries
        drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(3);

        rnd(500, 70, 60, 50, 60);
        for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
